// File: rtl/tmds_decoder.sv
// TMDS channel decoder: control-token word alignment (bit-slip hunt + lock
// tracking) and 10b->8b data recovery, all outputs registered.
module tmds_decoder #(
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SLIP_WAIT      = 16,
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned LOCK_TIMEOUT   = 8192
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] tmds_i,
  output logic [7:0] D,
  output logic       DE,
  output logic       C0,
  output logic       C1,
  output logic       bitslip_o,
  output logic       locked_o
);

  localparam int unsigned SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
  localparam int unsigned RW = $clog2(CTRL_RUN + 1);
  localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(SLIP_WAIT - 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(CTRL_RUN - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] search_tmr, search_tmr_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [RW-1:0] run_cnt, run_cnt_nxt;
  logic [LW-1:0] lock_tmr, lock_tmr_nxt;

  logic       is_ctrl;
  logic [1:0] ctrl_val;
  logic [7:0] t;
  logic [7:0] dec;

  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (tmds_i)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects)
  always_comb begin
    t      = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];
    dec    = '0;
    dec[0] = t[0];
    for (int unsigned i = 1; i < 8; i++)
      dec[i] = tmds_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= SEARCH;
      search_tmr <= '0;
      wait_cnt   <= '0;
      run_cnt    <= '0;
      lock_tmr   <= '0;
    end else begin
      state      <= state_nxt;
      search_tmr <= search_tmr_nxt;
      wait_cnt   <= wait_cnt_nxt;
      run_cnt    <= run_cnt_nxt;
      lock_tmr   <= lock_tmr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    search_tmr_nxt = search_tmr;
    wait_cnt_nxt   = wait_cnt;
    run_cnt_nxt    = run_cnt;
    lock_tmr_nxt   = lock_tmr;
    case (state)
      SEARCH: begin
        // A token on the timeout cycle clears the timer, so completing the run wins
        if (is_ctrl) begin
          search_tmr_nxt = '0;
          run_cnt_nxt    = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
          if (run_cnt == RUN_LAST) begin
            state_nxt    = LOCKED;
            lock_tmr_nxt = '0;
          end
        end else begin
          run_cnt_nxt = '0;
          if (search_tmr == SEARCH_LAST) begin
            state_nxt      = SLIP;
            search_tmr_nxt = '0;
          end else begin
            search_tmr_nxt = (search_tmr == '1) ? search_tmr : search_tmr + 1'b1;
          end
        end
      end
      SLIP: begin
        state_nxt      = WAIT;
        search_tmr_nxt = '0;
        wait_cnt_nxt   = '0;
        run_cnt_nxt    = '0;
        lock_tmr_nxt   = '0;
      end
      WAIT: begin
        run_cnt_nxt = '0;
        if (wait_cnt == WAIT_LAST) begin
          state_nxt      = SEARCH;
          wait_cnt_nxt   = '0;
          search_tmr_nxt = '0;
        end else begin
          wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          lock_tmr_nxt = '0;
        end else if (lock_tmr == LOCK_LAST) begin
          state_nxt      = SEARCH;
          lock_tmr_nxt   = '0;
          run_cnt_nxt    = '0;
          search_tmr_nxt = '0;
        end else begin
          lock_tmr_nxt = (lock_tmr == '1) ? lock_tmr : lock_tmr + 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      D         <= '0;
      DE        <= 1'b0;
      C0        <= 1'b0;
      C1        <= 1'b0;
      bitslip_o <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      bitslip_o <= (state_nxt == SLIP);
      locked_o  <= (state_nxt == LOCKED);
      if (is_ctrl) begin
        C1 <= ctrl_val[1];
        C0 <= ctrl_val[0];
        DE <= 1'b0;
        if (state != LOCKED) D <= '0;
      end else if (state == LOCKED) begin
        DE <= 1'b1;
        D  <= dec;
      end else begin
        DE <= 1'b0;
        D  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: a reference TMDS encoder produces the
// words, the expected byte is the one encoded, lock tracked by a simple model.
module tb_tmds_decoder;

  localparam int unsigned ST  = 64;
  localparam int unsigned SWT = 4;
  localparam int unsigned CR  = 8;
  localparam int unsigned LT  = 8192;
  localparam int unsigned P   = ST + 1 + SWT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds = '0;
  logic [7:0] d;
  logic       de, c0, c1, bs, lk;

  tmds_decoder #(
    .SEARCH_TIMEOUT(ST),
    .SLIP_WAIT     (SWT),
    .CTRL_RUN      (CR),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .tmds_i   (tmds),
    .D        (d),
    .DE       (de),
    .C0       (c0),
    .C1       (c1),
    .bitslip_o(bs),
    .locked_o (lk)
  );

  always #5 clk = ~clk;

  logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  logic [12:0] expq [$];
  string       tagq [$];
  int          checks = 0;
  int          failures = 0;

  logic [7:0] m_d = '0;
  logic [1:0] m_c = '0;
  bit         m_lk = 1'b0;
  int         m_run = 0;
  int         m_idle = 0;
  int         enc_cnt = 0;

  // DVI reference encoder with running disparity
  function automatic logic [9:0] tmds_enc(input logic [7:0] b);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q;
    bit xn;
    n1 = $countones(b);
    xn = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt = enc_cnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt = enc_cnt + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt = enc_cnt - 2 * int'(~qm[8]) + n1q - n0q;
    end
    return q;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] x;
    x = {w, w};
    return x[k +: 10];
  endfunction

  // force_lk < 0: lock expectation from the run/idle model, else forced value
  task automatic step(input logic [9:0] w, input logic [7:0] b, input bit exp_bs,
                      input int force_lk, input string tag);
    bit tok;
    logic [1:0] cv;
    bit lk_prev, lk_next, de_e;
    tok = 1'b0;
    cv = 2'b00;
    for (int i = 0; i < 4; i++)
      if (w == TOK[i]) begin tok = 1'b1; cv = 2'(i); end
    lk_prev = m_lk;
    tmds = w;
    @(posedge clk);
    #1;
    if (tok) begin
      m_c = cv;
      de_e = 1'b0;
      if (!lk_prev) m_d = '0;
    end else if (lk_prev) begin
      m_d = b;
      de_e = 1'b1;
    end else begin
      m_d = '0;
      de_e = 1'b0;
    end
    if (force_lk >= 0) begin
      lk_next = (force_lk != 0);
      m_run = 0;
      m_idle = 0;
    end else if (!lk_prev) begin
      m_run = tok ? m_run + 1 : 0;
      lk_next = (m_run >= int'(CR));
      if (lk_next) m_idle = 0;
    end else begin
      m_idle = tok ? 0 : m_idle + 1;
      lk_next = (m_idle < int'(LT));
      if (!lk_next) m_run = 0;
    end
    m_lk = lk_next;
    expq.push_back({m_d, de_e, m_c, lk_next, exp_bs});
    tagq.push_back(tag);
  endtask

  task automatic data_word(input logic [7:0] b, input bit exp_bs, input string tag);
    step(tmds_enc(b), b, exp_bs, -1, tag);
  endtask

  task automatic tok_word(input int i, input string tag);
    enc_cnt = 0;
    step(TOK[i], 8'h00, 1'b0, -1, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tmds = TOK[3];
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_d = '0; m_c = '0; m_lk = 1'b0; m_run = 0; m_idle = 0; enc_cnt = 0;
    expq.push_back(13'h0);
    tagq.push_back(tag);
  endtask

  logic [12:0] e_v;
  logic [12:0] act;
  string       e_tag;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e_v = expq.pop_front();
      e_tag = tagq.pop_front();
      act = {d, de, c1, c0, lk, bs};
      checks++;
      if (act !== e_v) begin
        failures++;
        $display("FAIL %0s: got D=%02h DE=%0b C1C0=%0b%0b locked=%0b bitslip=%0b, want D=%02h DE=%0b C1C0=%02b locked=%0b bitslip=%0b",
                 e_tag, d, de, c1, c0, lk, bs, e_v[12:5], e_v[4], e_v[3:2], e_v[1], e_v[0]);
      end
    end
  end

  logic [7:0] dirb [4] = '{8'h00, 8'hFF, 8'h55, 8'hA5};

  initial begin
    int mis;
    bit ebs, elk;

    // acquisition: seven tokens are not enough, eight are
    do_reset("reset");
    repeat (7) tok_word(0, "run7");
    data_word(8'($urandom), 1'b0, "run7_break");
    repeat (8) tok_word(0, "lock_acq");

    for (int i = 0; i < 4; i++) begin
      data_word(dirb[i], 1'b0, "dir_data");
      tok_word(i, "dir_tok");
    end
    for (int i = 0; i < 4; i++) begin
      tok_word(3 - i, "dir_tok2");
      data_word(dirb[i], 1'b0, "dir_data2");
    end

    for (int n = 0; n < 10000; n++) begin
      data_word(8'($urandom), 1'b0, "rand_data");
      if ($urandom_range(0, 31) == 0) tok_word(int'($urandom_range(0, 3)), "rand_tok");
    end

    // lock loss after LT data words, then recovery
    tok_word(2, "lt_start");
    for (int n = 0; n < int'(LT); n++) data_word(8'($urandom), 1'b0, "lock_timeout");
    repeat (5) data_word(8'($urandom), 1'b0, "unlocked_data");
    repeat (8) tok_word(1, "relock");
    for (int n = 0; n < 7999; n++) data_word(8'($urandom), 1'b0, "lt_hold");
    tok_word(0, "lt_refresh");
    for (int n = 0; n < 300; n++) data_word(8'($urandom), 1'b0, "lt_hold2");
    tok_word(3, "pre_rst");
    data_word(8'h3C, 1'b0, "pre_rst");

    do_reset("rst_locked");
    repeat (ST - 1) data_word(8'($urandom), 1'b0, "no_slip_a");
    do_reset("reset2");

    // search timeout boundary, then reset while waiting
    repeat (ST - 1) data_word(8'($urandom), 1'b0, "no_slip_b");
    data_word(8'($urandom), 1'b1, "slip_edge");
    data_word(8'($urandom), 1'b0, "slip_cycle");
    data_word(8'($urandom), 1'b0, "wait_cycle");
    do_reset("rst_wait");
    repeat (ST - 1) data_word(8'($urandom), 1'b0, "no_slip_c");

    // misaligned by 3 bits; one realignment per bitslip pulse
    do_reset("reset3");
    mis = 3;
    for (int n = 1; n <= int'(3 * P + CR + 10); n++) begin
      ebs = (n <= int'(2 * P + ST)) && ((n % int'(P)) == int'(ST));
      elk = (n >= int'(2 * P + ST + 1 + SWT + CR));
      step(rot(TOK[3], mis), 8'h00, ebs, elk ? 1 : 0, "align");
      if (bs && mis > 0) mis--;
    end
    data_word(8'hC3, 1'b0, "post_align");

    repeat (3) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
